// File: rtl/crforth_io_pkg.sv
// Shared definitions for the CPU I/O stall responder.
//   io_state_e   - responder FSM state encoding (2 bits)
//   IO_OUT/IO_IN - decode of the CPU's i_IOTYPE request bit
//   IN_ERR_VALUE - word returned to the register file when an IN times out
package crforth_io_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StOutWait = 2'd1,
    StInWait  = 2'd2,
    StDone    = 2'd3
  } io_state_e;

  localparam logic        IO_OUT       = 1'b0;
  localparam logic        IO_IN        = 1'b1;
  localparam logic [15:0] IN_ERR_VALUE = 16'hFFFF;

endpackage

// File: rtl/io_rx_buffer.sv
// One-entry holding register for peripheral RX words.
// Ports:
//   clk_i, rst_ni - clock and asynchronous active-low reset
//   fill_i        - capture data_i (caller only fills while empty)
//   data_i        - incoming word
//   pop_i         - consume the held word (caller only pops while full)
//   full_o        - a word is held
//   data_o        - held word
module io_rx_buffer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fill_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic [Width-1:0] data_o
);

  logic             full_q, full_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (pop_i) begin
      full_d = 1'b0;
    end
    if (fill_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/io_responder.sv
// Device-side responder for the CPU IN/OUT stall protocol. While the CPU
// holds i_IOPAUSE, an OUT presents i_OUTDATA on the TX valid/ready channel
// and an IN returns the buffered RX word; either way o_IODONE pulses for one
// cycle to release the stall. A per-request wait-state counter aborts the
// request with o_IOERR after TIMEOUT cycles (TIMEOUT=0 disables it).
// Ports:
//   i_CLK, i_RST_N          - clock, asynchronous active-low reset
//   i_IOPAUSE, i_IOTYPE     - CPU request and its direction (0=OUT, 1=IN)
//   i_OUTDATA               - OUT operand
//   o_INDATA                - IN result (held until the next IN completion)
//   o_IODONE, o_IOERR       - release pulse and timeout flag
//   o_TXVALID/o_TXDATA/i_TXREADY - TX channel
//   i_RXVALID/i_RXDATA/o_RXREADY - RX channel
module io_responder
  import crforth_io_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 10
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_IOPAUSE,
  input  logic        i_IOTYPE,
  input  logic [15:0] i_OUTDATA,
  output logic [15:0] o_INDATA,
  output logic        o_IODONE,
  output logic        o_IOERR,
  output logic        o_TXVALID,
  output logic [15:0] o_TXDATA,
  input  logic        i_TXREADY,
  input  logic        i_RXVALID,
  input  logic [15:0] i_RXDATA,
  output logic        o_RXREADY
);

  localparam logic             TimeoutEn   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

  io_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_valid_q, tx_valid_d;
  logic [15:0]      tx_data_q, tx_data_d;
  logic [15:0]      in_data_q, in_data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             rx_full;
  logic [15:0]      rx_data;
  logic             rx_fill;
  logic             rx_pop;
  logic             timed_out;

  // Ready drops during reset so no word is captured while the buffer is held.
  assign o_RXREADY = i_RST_N & ~rx_full;
  assign rx_fill   = i_RXVALID & o_RXREADY;
  assign timed_out = TimeoutEn && (cnt_q == TimeoutLast);

  io_rx_buffer #(
    .Width (16)
  ) u_rx_buffer (
    .clk_i  (i_CLK),
    .rst_ni (i_RST_N),
    .fill_i (rx_fill),
    .data_i (i_RXDATA),
    .pop_i  (rx_pop),
    .full_o (rx_full),
    .data_o (rx_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    in_data_d  = in_data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    rx_pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_IOPAUSE) begin
          cnt_d = '0;
          if (i_IOTYPE == IO_IN) begin
            state_d = StInWait;
          end else begin
            tx_data_d  = i_OUTDATA;
            tx_valid_d = 1'b1;
            state_d    = StOutWait;
          end
        end
      end

      StOutWait: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!i_IOPAUSE) begin
          // CPU withdrew the request: drop the word, no release pulse.
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end else if (tx_valid_q && i_TXREADY) begin
          // Completion is checked before the timeout so it wins a tie.
          tx_valid_d = 1'b0;
          err_d      = 1'b0;
          done_d     = 1'b1;
          state_d    = StDone;
        end else if (timed_out) begin
          tx_valid_d = 1'b0;
          err_d      = 1'b1;
          done_d     = 1'b1;
          state_d    = StDone;
        end
      end

      StInWait: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!i_IOPAUSE) begin
          // Buffered RX word stays put for a later IN.
          state_d = StIdle;
        end else if (rx_full) begin
          in_data_d = rx_data;
          rx_pop    = 1'b1;
          err_d     = 1'b0;
          done_d    = 1'b1;
          state_d   = StDone;
        end else if (timed_out) begin
          in_data_d = IN_ERR_VALUE;
          err_d     = 1'b1;
          done_d    = 1'b1;
          state_d   = StDone;
        end
      end

      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      in_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      in_data_q  <= in_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_INDATA  = in_data_q;
  assign o_IODONE  = done_q;
  assign o_IOERR   = err_q;
  assign o_TXVALID = tx_valid_q;
  assign o_TXDATA  = tx_data_q;

endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;
  import crforth_io_pkg::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iopause = 1'b0;
  logic        iotype = 1'b0;
  logic [15:0] outdata = '0;
  logic [15:0] indata;
  logic        iodone, ioerr, txvalid, rxready;
  logic [15:0] txdata;
  logic        txready = 1'b0;
  logic        rxvalid = 1'b0;
  logic [15:0] rxdata = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  io_responder #(
    .TIMEOUT (TO),
    .CNT_W   (4)
  ) dut (
    .i_CLK     (clk),
    .i_RST_N   (rst_n),
    .i_IOPAUSE (iopause),
    .i_IOTYPE  (iotype),
    .i_OUTDATA (outdata),
    .o_INDATA  (indata),
    .o_IODONE  (iodone),
    .o_IOERR   (ioerr),
    .o_TXVALID (txvalid),
    .o_TXDATA  (txdata),
    .i_TXREADY (txready),
    .i_RXVALID (rxvalid),
    .i_RXDATA  (rxdata),
    .o_RXREADY (rxready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Transaction-level model: a request is either pending or not; it ends by
  // handshake, buffered word, withdrawal or running out of wait cycles.
  logic [15:0] m_indata = '0, m_txdata = '0, m_rx_word = '0;
  logic        m_done = 1'b0, m_err = 1'b0, m_txvalid = 1'b0, m_rx_full = 1'b0;
  logic        m_busy = 1'b0, m_in = 1'b0;
  int          m_waited = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_indata <= '0; m_txdata <= '0; m_done <= 1'b0; m_err <= 1'b0;
      m_txvalid <= 1'b0; m_rx_full <= 1'b0; m_busy <= 1'b0; m_waited <= 0;
    end else begin
      if (m_done) begin
        m_done <= 1'b0;
        m_err  <= 1'b0;
      end else if (!m_busy) begin
        if (iopause) begin
          m_busy   <= 1'b1;
          m_in     <= iotype;
          m_waited <= 0;
          if (!iotype) begin
            m_txvalid <= 1'b1;
            m_txdata  <= outdata;
          end
        end
      end else if (!iopause) begin
        m_busy    <= 1'b0;
        m_txvalid <= 1'b0;
      end else if (!m_in && txready) begin
        m_busy <= 1'b0; m_txvalid <= 1'b0; m_err <= 1'b0; m_done <= 1'b1;
      end else if (m_in && m_rx_full) begin
        m_indata  <= m_rx_word;
        m_rx_full <= 1'b0;
        m_busy <= 1'b0; m_err <= 1'b0; m_done <= 1'b1;
      end else if (TO != 0 && m_waited == int'(TO) - 1) begin
        m_busy <= 1'b0; m_txvalid <= 1'b0; m_err <= 1'b1; m_done <= 1'b1;
        if (m_in) m_indata <= 16'hFFFF;
      end else begin
        m_waited <= m_waited + 1;
      end
      if (!m_rx_full && rxvalid) begin
        m_rx_full <= 1'b1;
        m_rx_word <= rxdata;
      end
    end
  end

  always @(negedge clk) begin
    chk("cycle", {indata, iodone, ioerr, txvalid, txdata, rxready},
        {m_indata, m_done, m_err, m_txvalid, m_txdata, rst_n & ~m_rx_full});
  end

  // Issue a request at posedge+1 and wait for the release pulse.
  task automatic do_io(input logic typ, input logic [15:0] d, input int rdy_at,
                       input bit keep, output int lat, output logic err,
                       output logic [15:0] ind, output int txc, output logic [15:0] txd);
    iopause = 1'b1;
    iotype  = typ;
    outdata = d;
    lat = 0; txc = 0; txd = '0; err = 1'bx; ind = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (txvalid) begin
        txc++;
        txd = txdata;
      end
      if (iodone) begin
        lat = c;
        err = ioerr;
        ind = indata;
        break;
      end
      @(posedge clk);
      #1;
      if (c == rdy_at) txready = 1'b1;
    end
    if (lat == 0) chk("iodone_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (!keep) iopause = 1'b0;
  endtask

  task automatic push_rx(input logic [15:0] w);
    rxvalid = 1'b1;
    rxdata  = w;
    @(posedge clk);
    #1;
    rxvalid = 1'b0;
  endtask

  initial begin
    int          lat, txc;
    logic        err;
    logic [15:0] ind, txd;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Async reset while an OUT word is being offered.
    iopause = 1'b1; iotype = IO_OUT; outdata = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_txvalid", txvalid, 1);
    chk("rst_pre_txdata", txdata, 16'h1234);
    #2 rst_n = 1'b0;
    iopause = 1'b0;
    #1;
    chk("rst_txvalid", txvalid, 0);
    chk("rst_rxready", rxready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_rxready", rxready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_done", iodone, 0);
    end
    @(posedge clk);
    #1;

    // OUT with the peripheral always ready.
    txready = 1'b1;
    do_io(IO_OUT, 16'hBEEF, 0, 0, lat, err, ind, txc, txd);
    chk("out_lat", lat, 3);
    chk("out_err", err, 0);
    chk("out_txcycles", txc, 1);
    chk("out_txdata", txd, 16'hBEEF);
    txready = 1'b0;

    // RX word arrives well before the IN.
    push_rx(16'h00A5);
    @(negedge clk);
    chk("rx_held_ready", rxready, 0);
    repeat (3) @(posedge clk);
    #1;
    do_io(IO_IN, 16'h0000, 0, 0, lat, err, ind, txc, txd);
    chk("in_lat", lat, 3);
    chk("in_data", ind, 16'h00A5);
    chk("in_err", err, 0);
    @(negedge clk);
    chk("in_ready_back", rxready, 1);

    // IN with nothing buffered times out.
    @(posedge clk);
    #1;
    do_io(IO_IN, 16'h0000, 0, 0, lat, err, ind, txc, txd);
    chk("in_to_lat", lat, TO + 2);
    chk("in_to_err", err, 1);
    chk("in_to_data", ind, 16'hFFFF);
    push_rx(16'h5A5A);
    @(negedge clk);
    chk("rx_after_to", rxready, 0);
    @(posedge clk);
    #1;
    do_io(IO_IN, 16'h0000, 0, 0, lat, err, ind, txc, txd);
    chk("in2_data", ind, 16'h5A5A);

    // OUT with no ready times out and leaves o_INDATA alone.
    do_io(IO_OUT, 16'h1111, 0, 0, lat, err, ind, txc, txd);
    chk("out_to_lat", lat, TO + 2);
    chk("out_to_err", err, 1);
    chk("out_to_indata", ind, 16'h5A5A);

    // Ready arrives on the very edge the timeout would fire.
    do_io(IO_OUT, 16'h2222, TO, 0, lat, err, ind, txc, txd);
    chk("race_lat", lat, TO + 2);
    chk("race_err", err, 0);

    // Back-to-back OUT then IN with i_IOPAUSE held high.
    push_rx(16'h7777);
    do_io(IO_OUT, 16'h0001, 0, 1, lat, err, ind, txc, txd);
    chk("b2b_out_lat", lat, 3);
    chk("b2b_out_txdata", txd, 16'h0001);
    do_io(IO_IN, 16'h0000, 0, 0, lat, err, ind, txc, txd);
    chk("b2b_in_lat", lat, 3);
    chk("b2b_in_data", ind, 16'h7777);
    txready = 1'b0;

    // CPU withdraws an IN: no release pulse.
    iopause = 1'b1; iotype = IO_IN;
    repeat (3) @(posedge clk);
    #1 iopause = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", iodone, 0);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
